// File: rtl/regfile_pkg.sv
// Shared widths and types for the register-file debug dumper.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    SEND,
    FIN
  } dump_state_e;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] idx;
    logic [XLEN-1:0]       data;
    logic                  last;
  } beat_t;

endpackage

// File: rtl/regfile_dumper.sv
// Walks FIRST_REG..LAST_REG through a debug read port, one valid/ready beat per register; flags stale on snooped overwrites.
// Latency: first beat valid 2 cycles after start, 2 cycles per register with out_ready high.
// Backpressure: beat held stable in SEND while out_ready is low. Option macro: DUMP_SKIP_ZERO_EN (zero values skipped).
module regfile_dumper
  import regfile_pkg::*;
#(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  output logic                  busy,
  output logic [REG_ADDR_W-1:0] rd_addr,
  input  logic [XLEN-1:0]       rd_data,
  input  logic                  snoop_we,
  input  logic [REG_ADDR_W-1:0] snoop_addr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [REG_ADDR_W-1:0] out_idx,
  output logic [XLEN-1:0]       out_data,
  output logic                  out_last,
  output logic                  done,
  output logic                  stale
);

  localparam logic [REG_ADDR_W-1:0] FIRST_IDX = REG_ADDR_W'(FIRST_REG);
  localparam logic [REG_ADDR_W-1:0] LAST_IDX  = REG_ADDR_W'(LAST_REG);

  dump_state_e           state_q, state_d;
  logic [REG_ADDR_W-1:0] cur_idx;
  beat_t                 beat_q;
  logic                  load_idx, inc_idx, capture, at_last, skip;

  assign at_last = (cur_idx == LAST_IDX);

`ifdef DUMP_SKIP_ZERO_EN
  assign skip = (rd_data == '0);
`else
  assign skip = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    load_idx = 1'b0;
    inc_idx  = 1'b0;
    capture  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load_idx = 1'b1;
          state_d  = READ;
        end
      end
      READ: begin
        capture = !skip;
        if (!skip) begin
          state_d = SEND;
        end else if (at_last) begin
          state_d = FIN;
        end else begin
          inc_idx = 1'b1;
          state_d = READ;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (at_last) begin
            state_d = FIN;
          end else begin
            inc_idx = 1'b1;
            state_d = READ;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A write at or below cur_idx hits a register that is already captured (or is
  // being captured this edge, which still sees the pre-write value).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cur_idx <= '0;
      beat_q  <= '0;
      stale   <= 1'b0;
    end else begin
      if (load_idx)     cur_idx <= FIRST_IDX;
      else if (inc_idx) cur_idx <= cur_idx + REG_ADDR_W'(1);

      if (capture) beat_q <= '{idx: cur_idx, data: rd_data, last: at_last};

      if (load_idx)
        stale <= 1'b0;
      else if (busy && snoop_we && (snoop_addr != '0) && (snoop_addr <= cur_idx))
        stale <= 1'b1;
    end
  end

  assign busy      = (state_q == READ) || (state_q == SEND);
  assign done      = (state_q == FIN);
  assign out_valid = (state_q == SEND);
  assign rd_addr   = (state_q == IDLE) ? '0 : cur_idx;
  assign out_idx   = beat_q.idx;
  assign out_data  = beat_q.data;
  assign out_last  = beat_q.last;

endmodule

// File: doc/regfile_dumper.md
# regfile_dumper

Debug read-out engine for the pipelined RISC-V core's integer register file. On a start request it walks registers FIRST_REG..LAST_REG through a dedicated read port and streams each value out as one beat on a valid/ready interface. Concurrent pipeline writebacks can change the register file during a dump. The block snoops the register-file write port and flags the dump as stale if any already-captured register changes. It sits beside `regfile` and feeds the debug/trace link.

## Interface
- FIRST_REG, default 0: first register index dumped (0..31).
- LAST_REG, default 31: last register index dumped (must be ≥ FIRST_REG).
- clk  in  1  system clock; all state changes on the rising edge.
- rstn  in  1  asynchronous, active-low reset.
- start  in  1  dump request; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until done.
- rd_addr  out  5  register index driven to the register-file debug read port.
- rd_data  in  32  combinational read data for rd_addr, valid in the same cycle.
- snoop_we  in  1  register-file write_en.
- snoop_addr  in  5  register-file write_reg.
- out_valid  out  1  beat valid.
- out_ready  in  1  consumer accepts the beat when valid && ready.
- out_idx  out  5  register index of the beat.
- out_data  out  32  captured register value.
- out_last  out  1  beat carries LAST_REG.
- done  out  1  one-cycle pulse after the final register is handled.
- stale  out  1  sticky; the dump may not be a coherent snapshot. Cleared on start.

## Operation
- Reset values of all outputs are 0: busy, rd_addr, out_valid, out_idx, out_data, out_last, done, stale. The state is IDLE and the index counter is 0.
- The FSM has four states: IDLE, READ, SEND, FIN.
- IDLE: when start=1, load cur_idx=FIRST_REG, clear stale, and go to READ. busy rises in the next cycle.
- READ:
  - rd_addr=cur_idx.
  - On the edge, capture rd_data into out_data and cur_idx into out_idx.
  - Set out_last = (cur_idx==LAST_REG).
  - Go to SEND.
- SEND:
  - out_valid=1, and out_idx, out_data and out_last stay stable until the handshake.
  - On valid && ready: if cur_idx==LAST_REG, go to FIN. Otherwise increment cur_idx and go to READ.
- FIN: assert done for one cycle, drop busy, and return to IDLE.
- start while busy is ignored. There is no queueing.
- rd_addr holds cur_idx in every state other than IDLE. In IDLE it is 0.
- Stale rule:
  - stale is set in any cycle where busy && snoop_we && snoop_addr!=0 && snoop_addr<=cur_idx.
  - A write to cur_idx during READ sets stale because the capture edge coincides with the write commit, so the old value is captured.
  - Writes to indices above cur_idx never set stale.
  - Writes to x0 never set stale.
- stale holds its value through FIN and IDLE until the next accepted start.
- Reset mid-dump aborts immediately: no done pulse, and all outputs return to reset values asynchronously.

## Timing
- Start sampled at edge E: READ in E+1 → SEND in E+2 → out_valid visible in cycle E+2.
- With out_ready tied high, each register takes 2 cycles. A full 32-register dump takes 64 cycles from accept to the last handshake; done follows in the next cycle.
- out_ready deasserted stalls in SEND indefinitely. No beat is dropped or duplicated.
- out_valid never falls without a handshake, except under reset.

## Configuration
- DUMP_SKIP_ZERO_EN, when defined: in READ, a captured value of 0 skips SEND.
  - If cur_idx==LAST_REG, go to FIN. Otherwise increment and go to READ.
  - x0 is therefore never emitted.
  - If LAST_REG reads zero, no out_last beat occurs; done still pulses.
- When undefined: every register in range produces exactly one beat, including x0 (value 0).

## Structure
- Shared package `regfile_pkg` holds:
  - REG_ADDR_W=5 and XLEN=32.
  - The dumper state enum (IDLE, READ, SEND, FIN).
  - The beat struct {idx, data, last}.
- No sub-module is needed. The FSM, index counter, holding register and stale flag form one module.

## Test plan
- Write x5=A5A5A5A5, x6=5A5A5A5A and x11=12345678, then pulse start with out_ready=1 → 32 beats, idx 0..31 in order. Beat 5=A5A5A5A5, beat 6=5A5A5A5A, beat 11=12345678, all others 0. out_last only on idx 31. done at accept+65. stale=0.
- Same preload, out_ready toggling 1-of-3 cycles → identical beat sequence, with data held stable while valid && !ready.
- During the dump, write x5=DEADBEEF while cur_idx=11 → stale=1 and beat 5 still A5A5A5A5. Writing x20 at that point instead → stale=0 and beat 20=value written.
- Pulse start mid-dump → ignored, no restart. Assert rstn=0 at beat 7 → outputs 0 at once, no done. Start after release → full dump from idx 0.
- With DUMP_SKIP_ZERO_EN and the preload above → exactly 3 beats (5, 6, 11), no out_last, done pulses once.
